// File: rtl/frogger_vga_out.sv
// VGA back end for the Frogger pixel generator: scan counters, palette lookup
// and sync/blank pins, all delayed so they line up with the RGB they frame.
module frogger_vga_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    input  logic [0:5] colorcode,
    output logic       pix_en,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    function automatic logic [23:0] palette(input logic [5:0] code);
        case (code)
            6'd0:    palette = 24'hFFFFFF;
            6'd1:    palette = 24'h000000;
            6'd2:    palette = 24'h27B212;
            6'd3:    palette = 24'hD80222;
            6'd4:    palette = 24'h5DB1F0;
            6'd5:    palette = 24'hF1FF0A;
            6'd6:    palette = 24'hB2B2B0;
            6'd7:    palette = 24'hF27A00;
            6'd8:    palette = 24'h663300;
            6'd9:    palette = 24'h8600B3;
            6'd10:   palette = 24'h000066;
            default: palette = 24'h000000;
        endcase
    endfunction

    logic [DIV_W-1:0] div;
    logic [9:0]       hc, vc;
    logic [5:0]       code_in;
    logic             act_now, hs_now, vs_now;
    logic [5:0]       code_s1;
    logic             act_s1, hs_s1, vs_s1;
    logic [23:0]      rgb_s2;

    assign code_in = colorcode;
    assign DrawX   = hc;
    assign DrawY   = vc;

    // Raw timing for the pixel currently addressed by (hc, vc).
    always_comb begin
        act_now = (hc < H_ACT) && (vc < V_ACT);
        hs_now  = !((hc >= HS_BEG) && (hc <= HS_END));
        vs_now  = !((vc >= VS_BEG) && (vc <= VS_END));
    end

    // Combinational from registers only, so it pulses exactly with the wrapping tick.
    assign frame_start = pix_en && (hc == H_LAST) && (vc == V_LAST);

    // NOTE: every register here uses <= so all stages sample the values from
    // before this edge; blocking assignments would collapse the pipeline.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            code_s1     <= '0;
            act_s1      <= 1'b0;
            hs_s1       <= 1'b1;
            vs_s1       <= 1'b1;
            rgb_s2      <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            pix_en <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
                code_s1     <= code_in;
                act_s1      <= act_now;
                hs_s1       <= hs_now;
                vs_s1       <= vs_now;
                rgb_s2      <= act_s1 ? palette(code_s1) : 24'h000000;
                VGA_HS      <= hs_s1;
                VGA_VS      <= vs_s1;
                VGA_BLANK_N <= act_s1;
            end
        end
    end

    assign VGA_R = rgb_s2[23:16];
    assign VGA_G = rgb_s2[15:8];
    assign VGA_B = rgb_s2[7:0];

endmodule

// File: tb/tb_frogger_vga_out.sv
// Randomised bench for frogger_vga_out on a shrunken video mode; expected pins
// come from scan-position arithmetic and a two-tick expectation queue.
module tb_frogger_vga_out;

    localparam int HV = 160, HF = 16, HSW = 24, HB = 20;
    localparam int VV = 30,  VF = 3,  VSW = 2,  VB = 5;
    localparam int DIV = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam logic [26:0] RESET_PINS = {1'b1, 1'b1, 1'b0, 24'h000000};

    logic       Clk, Reset;
    logic [9:0] DrawX, DrawY;
    logic [5:0] cc;
    logic       pix_en, frame_start, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    frogger_vga_out #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(DIV)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .colorcode(cc), .pix_en(pix_en), .frame_start(frame_start),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int passed = 0;
    logic [26:0] exp_q[$];
    logic [23:0] pal_tbl [0:10] = '{24'hFFFFFF, 24'h000000, 24'h27B212, 24'hD80222,
                                    24'h5DB1F0, 24'hF1FF0A, 24'hB2B2B0, 24'hF27A00,
                                    24'h663300, 24'h8600B3, 24'h000066};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [26:0] model(input int x, input int y, input int code);
        logic        act, hs_n, vs_n;
        logic [23:0] rgb;
        act  = (x < HV) && (y < VV);
        hs_n = !(x >= HV + HF && x < HV + HF + HSW);
        vs_n = !(y >= VV + VF && y < VV + VF + VSW);
        rgb  = (act && code <= 10) ? pal_tbl[code] : 24'h000000;
        return {hs_n, vs_n, act, rgb};
    endfunction

    function automatic logic [26:0] pins_now();
        return {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_pos"}, 32'({DrawY, DrawX}), 32'd0);
        chk({tag, "_pins"}, 32'(pins_now()), 32'(RESET_PINS));
        chk({tag, "_pix_en"}, 32'(pix_en), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    // Runs from a reset release (made at a negedge) through tick last_tick.
    // In directed mode, frame 0 drives code 3 only at (100,20).
    task automatic run(input int last_tick, input bit directed);
        int cyc = 0, k = 0, cur_code = 0, x, y, first_pe = -1;
        int hs_fall = -1, vs_fall = -1, fs_last = -1, fs_cnt = 0, red_cnt = 0;
        bit pe_exp, last, first_fall = 1'b0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        logic [26:0] expv;
        exp_q.delete();
        exp_q.push_back(RESET_PINS);
        exp_q.push_back(RESET_PINS);
        while (k <= last_tick) begin
            @(negedge Clk);
            cyc++;
            x      = k % HT;
            y      = (k / HT) % VT;
            pe_exp = (cyc % DIV == 0);
            last   = (x == HT - 1) && (y == VT - 1);
            if (pix_en && first_pe < 0) first_pe = cyc;
            chk("pix_en", 32'(pix_en), 32'(pe_exp));
            chk("frame_start", 32'(frame_start), 32'(pe_exp && last));
            if (!pe_exp) begin
                if (directed && k < FRAME) begin
                    if (x == 100 && y == 20) cur_code = 3;
                    else begin
                        cur_code = int'($urandom_range(0, 62));
                        if (cur_code >= 3) cur_code++;
                    end
                end else begin
                    cur_code = int'($urandom_range(0, 63));
                end
                cc = 6'(cur_code);
            end else begin
                chk("pos", 32'({DrawY, DrawX}), 32'({10'(y), 10'(x)}));
                expv = exp_q.pop_front();
                chk("pins", 32'(pins_now()), 32'(expv));
                if (directed && k >= 2 && k < FRAME + 2 && {VGA_R, VGA_G, VGA_B} == 24'hD80222)
                    red_cnt++;
                exp_q.push_back(model(x, y, cur_code));
                k++;
            end
            if (prev_hs && !VGA_HS) begin
                if (!first_fall) begin
                    chk("hs_first_fall_x", 32'(DrawX), 32'(HV + HF + 2));
                    first_fall = 1'b1;
                end
                if (hs_fall >= 0) chk("hs_period", 32'(cyc - hs_fall), 32'(HT * DIV));
                hs_fall = cyc;
            end
            if (!prev_hs && VGA_HS && hs_fall >= 0)
                chk("hs_low_width", 32'(cyc - hs_fall), 32'(HSW * DIV));
            if (prev_vs && !VGA_VS) vs_fall = cyc;
            if (!prev_vs && VGA_VS && vs_fall >= 0)
                chk("vs_low_width", 32'(cyc - vs_fall), 32'(VSW * HT * DIV));
            if (frame_start) begin
                if (fs_last >= 0) chk("frame_period", 32'(cyc - fs_last), 32'(FRAME * DIV));
                fs_last = cyc;
                fs_cnt++;
            end
            prev_hs = VGA_HS;
            prev_vs = VGA_VS;
        end
        chk("first_pix_en_delay", 32'(first_pe), 32'(DIV));
        chk("hs_fall_seen", 32'(first_fall), 32'd1);
        chk("frame_start_count", 32'(fs_cnt), 32'((last_tick + 1) / FRAME));
        if (directed) chk("red_pixel_count", 32'(red_cnt), 32'd1);
    endtask

    initial begin
        Reset = 1'b1;
        cc    = 6'd0;
        repeat (3) @(negedge Clk);
        check_reset_state("reset");
        Reset = 1'b0;

        // Two full frames, then stop mid-frame at (150,25) on a pix_en cycle.
        run(2 * FRAME + 25 * HT + 150, 1'b1);

        Reset = 1'b1;
        @(negedge Clk);
        check_reset_state("mid_reset");
        repeat (2) @(negedge Clk);
        check_reset_state("mid_reset_hold");
        Reset = 1'b0;

        run(3 * HT - 1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
